// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types and constants for the frame-buffer scheduler.
package frame_buffer_scheduler_pkg;

  // Port ownership state: free drawing, waiting for the frame boundary, clearing the new back page
  typedef enum logic [1:0] {
    ST_DRAW    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } fbs_state_e;

  // 1280x720 timing totals the scheduler is built around
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int H_TOTAL  = 1650;
  localparam int V_TOTAL  = 750;

  // Width of a linear pixel index within one page
  function automatic int fb_addr_w(input int width, input int height);
    return $clog2(width * height);
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_sig_delay.sv
// Fixed-depth shift register used to align timing signals with the pixel pipeline.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] pipe_d [DEPTH];
  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Next stage values: new sample enters stage 0, the rest move one stage down
  always_comb begin
    pipe_d[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Delay stages, cleared on reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign data_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Single-port frame-buffer arbiter: scan-out reads take every scan slot, draw
// writes and page clears share the remaining cycles; two pages are swapped at
// the frame boundary on request.
module frame_buffer_scheduler
  import frame_buffer_scheduler_pkg::*;
#(
  parameter int                     FB_WIDTH      = 320,
  parameter int                     FB_HEIGHT     = 180,
  parameter int                     SCALE_LOG2    = 2,
  parameter int                     PIXEL_WIDTH   = 8,
  parameter int                     READ_LATENCY  = 2,
  parameter bit                     CLEAR_ON_SWAP = 1'b1,
  parameter logic [PIXEL_WIDTH-1:0] CLEAR_COLOR   = '0,
  localparam int ADDR_W = 1 + fb_addr_w(FB_WIDTH, FB_HEIGHT)
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   ad_in,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   nf_in,
  input  logic                   wr_valid_in,
  output logic                   wr_ready_out,
  input  logic [8:0]             wr_x_in,
  input  logic [7:0]             wr_y_in,
  input  logic [PIXEL_WIDTH-1:0] wr_data_in,
  input  logic                   swap_req_in,
  output logic                   swap_ack_out,
  output logic                   busy_out,
  output logic [ADDR_W-1:0]      mem_addr_out,
  output logic                   mem_we_out,
  output logic [PIXEL_WIDTH-1:0] mem_din_out,
  input  logic [PIXEL_WIDTH-1:0] mem_dout_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic [10:0]            hcount_out,
  output logic [9:0]             vcount_out,
  output logic                   ad_out,
  output logic                   hs_out,
  output logic                   vs_out
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int LAT   = READ_LATENCY + 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(FB_WIDTH);
  localparam logic [9:0]       X_LIMIT   = 10'(FB_WIDTH);
  localparam logic [8:0]       Y_LIMIT   = 9'(FB_HEIGHT);

  fbs_state_e               state_d, state_q;
  logic                     front_d, front_q;
  logic [IDX_W-1:0]         clr_cnt_d, clr_cnt_q;
  logic                     swap_ack_d, swap_ack_q;
  logic                     busy_d, busy_q;
  logic [ADDR_W-1:0]        mem_addr_d, mem_addr_q;
  logic                     mem_we_d, mem_we_q;
  logic [PIXEL_WIDTH-1:0]   mem_din_d, mem_din_q;
  logic [READ_LATENCY:0]    rd_vld_d, rd_vld_q;
  logic [READ_LATENCY:0]    ad_pipe_d, ad_pipe_q;
  logic [PIXEL_WIDTH-1:0]   pixel_d, pixel_q;
  logic [IDX_W-1:0]         row_base_d, row_base_q;
  logic [9:0]               vcount_d, vcount_q;

  logic                     scan_slot_s;
  logic [IDX_W-1:0]         scan_idx_s;
  logic [IDX_W-1:0]         wr_idx_s;
  logic                     wr_in_range_s;
  logic                     wr_fire_s;

  // Slot decode and scan address; the row base advances by one source row
  // whenever vcount crosses an upscale boundary, so no multiplier on the scan path
  always_comb begin
    scan_slot_s = ad_in && (hcount_in[SCALE_LOG2-1:0] == '0);
    vcount_d    = vcount_in;
    if (vcount_in != vcount_q) begin
      if (vcount_in == 10'd0) begin
        row_base_d = '0;
      end else if (vcount_in[SCALE_LOG2-1:0] == '0) begin
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        row_base_d = row_base_q;
      end
    end else begin
      row_base_d = row_base_q;
    end
    scan_idx_s    = row_base_d + IDX_W'(hcount_in >> SCALE_LOG2);
    wr_idx_s      = IDX_W'(wr_y_in) * ROW_STEP + IDX_W'(wr_x_in);
    wr_in_range_s = ({1'b0, wr_x_in} < X_LIMIT) && ({1'b0, wr_y_in} < Y_LIMIT);
  end

  // Draw engine may only write in DRAW on a free slot; forced low while in reset
  assign wr_ready_out = rst_n_in && (state_q == ST_DRAW) && !scan_slot_s;
  assign wr_fire_s    = wr_valid_in && wr_ready_out;

  // Page FSM, clear counter and memory port mux (scan > clear > draw write)
  always_comb begin
    state_d    = state_q;
    front_d    = front_q;
    clr_cnt_d  = clr_cnt_q;
    swap_ack_d = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    case (state_q)
      ST_DRAW: begin
        if (swap_req_in) begin
          state_d = ST_PENDING;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_PENDING: begin
        if (nf_in) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
          clr_cnt_d  = '0;
          state_d    = CLEAR_ON_SWAP ? ST_CLEAR : ST_DRAW;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_CLEAR: begin
        if (!scan_slot_s) begin
          if (clr_cnt_q == LAST_IDX) begin
            clr_cnt_d = '0;
            state_d   = ST_DRAW;
          end else begin
            clr_cnt_d = clr_cnt_q + IDX_W'(1);
          end
        end else begin
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: begin
        state_d = ST_DRAW;
      end
    endcase

    if (scan_slot_s) begin
      mem_addr_d = {front_q, scan_idx_s};
    end else if (state_q == ST_CLEAR) begin
      mem_we_d   = 1'b1;
      mem_addr_d = {~front_q, clr_cnt_q};
      mem_din_d  = CLEAR_COLOR;
    end else if (wr_fire_s && wr_in_range_s) begin
      mem_we_d   = 1'b1;
      mem_addr_d = {~front_q, wr_idx_s};
      mem_din_d  = wr_data_in;
    end else begin
      mem_we_d = 1'b0;
    end
    busy_d = (state_d != ST_DRAW);
  end

  // Read-return tracking: capture BRAM data exactly when a scan read returns,
  // blank outside the active area, otherwise hold across the upscale cycles
  always_comb begin
    rd_vld_d  = {rd_vld_q[READ_LATENCY-1:0], scan_slot_s};
    ad_pipe_d = {ad_pipe_q[READ_LATENCY-1:0], ad_in};
    if (rd_vld_q[READ_LATENCY]) begin
      pixel_d = mem_dout_in;
    end else if (!ad_pipe_q[READ_LATENCY]) begin
      pixel_d = '0;
    end else begin
      pixel_d = pixel_q;
    end
  end

  // State and output registers; reset discards any reads in flight
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_DRAW;
      front_q    <= 1'b0;
      clr_cnt_q  <= '0;
      swap_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
      rd_vld_q   <= '0;
      ad_pipe_q  <= '0;
      pixel_q    <= '0;
      row_base_q <= '0;
      vcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      clr_cnt_q  <= clr_cnt_d;
      swap_ack_q <= swap_ack_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      rd_vld_q   <= rd_vld_d;
      ad_pipe_q  <= ad_pipe_d;
      pixel_q    <= pixel_d;
      row_base_q <= row_base_d;
      vcount_q   <= vcount_d;
    end
  end

  sig_delay #(
    .WIDTH (24),
    .DEPTH (LAT)
  ) u_timing_delay (
    .clk_in   (pixel_clk_in),
    .rst_n_in (rst_n_in),
    .data_in  ({hcount_in, vcount_in, ad_in, hs_in, vs_in}),
    .data_out ({hcount_out, vcount_out, ad_out, hs_out, vs_out})
  );

  assign swap_ack_out = swap_ack_q;
  assign busy_out     = busy_q;
  assign mem_addr_out = mem_addr_q;
  assign mem_we_out   = mem_we_q;
  assign mem_din_out  = mem_din_q;
  assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with a 2-cycle BRAM model whose
// contents are the low 8 address bits.
module tb_frame_buffer_scheduler;

  logic        pixel_clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        ad_in, hs_in, vs_in, nf_in;
  logic        wr_valid_in, wr_ready_out;
  logic [8:0]  wr_x_in;
  logic [7:0]  wr_y_in;
  logic [7:0]  wr_data_in;
  logic        swap_req_in, swap_ack_out, busy_out;
  logic [16:0] mem_addr_out;
  logic        mem_we_out;
  logic [7:0]  mem_din_out;
  logic [7:0]  mem_dout_in;
  logic [7:0]  pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        ad_out, hs_out, vs_out;

  always #5 pixel_clk_in = ~pixel_clk_in;

  frame_buffer_scheduler dut (
    .pixel_clk_in (pixel_clk_in), .rst_n_in     (rst_n_in),
    .hcount_in    (hcount_in),    .vcount_in    (vcount_in),
    .ad_in        (ad_in),        .hs_in        (hs_in),
    .vs_in        (vs_in),        .nf_in        (nf_in),
    .wr_valid_in  (wr_valid_in),  .wr_ready_out (wr_ready_out),
    .wr_x_in      (wr_x_in),      .wr_y_in      (wr_y_in),
    .wr_data_in   (wr_data_in),   .swap_req_in  (swap_req_in),
    .swap_ack_out (swap_ack_out), .busy_out     (busy_out),
    .mem_addr_out (mem_addr_out), .mem_we_out   (mem_we_out),
    .mem_din_out  (mem_din_out),  .mem_dout_in  (mem_dout_in),
    .pixel_out    (pixel_out),    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),   .ad_out       (ad_out),
    .hs_out       (hs_out),       .vs_out       (vs_out)
  );

  // BRAM model: address registered, data one cycle later (2-cycle latency)
  logic [16:0] ram_a1 = '0;
  always @(posedge pixel_clk_in) begin
    ram_a1      <= mem_addr_out;
    mem_dout_in <= ram_a1[7:0];
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] hist [4];
  bit          lag_en = 1'b0;
  bit          clr_mon = 1'b0;
  logic [7:0]  exp_pix = 8'd0;
  logic        front_exp = 1'b0;
  logic        exp_page = 1'b0;
  logic [15:0] clr_exp = 16'd0;
  int          clr_cnt = 0;
  int          clr_bad = 0;
  int          scan_lost = 0;
  bit          prev_slot = 1'b0;
  logic [16:0] prev_rd_addr = '0;
  int          fall_cnt = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Low byte of the source-pixel index for packed {h,v,ad,hs,vs}
  function automatic logic [7:0] rd_lsb(input logic [23:0] s);
    int idx;
    idx = int'(s[12:5]) * 320 + int'(s[23:15]);
    return idx[7:0];
  endfunction

  // One clock: sample outputs at negedge, update models, return 1ns after posedge
  task automatic tick();
    logic [23:0] cur;
    logic [23:0] outv;
    int          idx;
    @(negedge pixel_clk_in);
    cur  = {hcount_in, vcount_in, ad_in, hs_in, vs_in};
    outv = {hcount_out, vcount_out, ad_out, hs_out, vs_out};
    if (lag_en) begin
      check_eq("lag4", outv, hist[3]);
      if (!hist[3][2]) exp_pix = 8'd0;
      else if (hist[3][14:13] == 2'b00) exp_pix = rd_lsb(hist[3]);
      check_eq("pix_model", pixel_out, exp_pix);
      if (hist[3][2] && hist[3][23:13] == 11'd4 && hist[3][12:3] == 10'd0)
        check_eq("pix_v0_h4", pixel_out, 8'd1);
      if (hist[3][2] && hist[3][23:13] == 11'd4 && hist[3][12:3] == 10'd4)
        check_eq("pix_v4_h4", pixel_out, 8'd65);
    end
    if (clr_mon) begin
      if (mem_we_out) begin
        if (mem_din_out !== 8'd0 || mem_addr_out !== {exp_page, clr_exp}) clr_bad++;
        clr_exp++;
        clr_cnt++;
      end
      if (prev_slot && (mem_we_out || mem_addr_out !== prev_rd_addr)) scan_lost++;
    end
    prev_slot    = ad_in && (hcount_in[1:0] == 2'b00);
    idx          = int'(vcount_in >> 2) * 320 + int'(hcount_in >> 2);
    prev_rd_addr = {front_exp, idx[15:0]};
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
    @(posedge pixel_clk_in);
    #1;
  endtask

  initial begin
    rst_n_in = 1'b0; hcount_in = '0; vcount_in = '0; ad_in = 0; hs_in = 0; vs_in = 0;
    nf_in = 0; wr_valid_in = 0; wr_x_in = '0; wr_y_in = '0; wr_data_in = '0; swap_req_in = 0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    repeat (3) @(posedge pixel_clk_in);
    #1;
    // Reset state
    check_eq("rst_pixel", pixel_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_we", mem_we_out, 0);
    check_eq("rst_addr", mem_addr_out, 0);
    check_eq("rst_ready", wr_ready_out, 0);
    rst_n_in = 1'b1;
    tick();

    // Scan-out over five short lines, checking latency and pixel values
    lag_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 20; h++) begin
        hcount_in = 11'(h); vcount_in = 10'(v);
        ad_in = (h < 16); hs_in = (h >= 17); vs_in = (v == 4);
        tick();
      end
    end
    ad_in = 0; hs_in = 0; vs_in = 0;
    repeat (6) tick();
    lag_en = 1'b0;

    // Held write request: blocked on scan slot, accepted on the next free slot
    vcount_in = 10'd10; ad_in = 1; hcount_in = 11'd0;
    wr_valid_in = 1; wr_x_in = 9'd5; wr_y_in = 8'd2; wr_data_in = 8'hAB;
    #1 check_eq("rdy_scan_slot", wr_ready_out, 0);
    tick();
    hcount_in = 11'd1;
    #1 check_eq("rdy_free_slot", wr_ready_out, 1);
    tick();
    wr_valid_in = 0; hcount_in = 11'd2;
    #1;
    check_eq("wr_we", mem_we_out, 1);
    check_eq("wr_addr", mem_addr_out, 17'd66181);
    check_eq("wr_data", mem_din_out, 8'hAB);
    tick();
    hcount_in = 11'd3;
    #1 check_eq("wr_once", mem_we_out, 0);
    tick();

    // Out-of-range writes complete the handshake but never reach memory
    ad_in = 0; wr_valid_in = 1; wr_x_in = 9'd320; wr_y_in = 8'd0;
    #1 check_eq("rdy_oob_x", wr_ready_out, 1);
    tick();
    wr_x_in = 9'd0; wr_y_in = 8'd180;
    #1 check_eq("we_oob_x", mem_we_out, 0);
    tick();
    wr_valid_in = 0;
    #1 check_eq("we_oob_y", mem_we_out, 0);
    tick();

    // Swap request coincident with nf: only enters PENDING
    vcount_in = 10'd100; swap_req_in = 1; nf_in = 1;
    tick();
    swap_req_in = 0; nf_in = 0; wr_valid_in = 1;
    #1;
    check_eq("busy_pending", busy_out, 1);
    check_eq("rdy_pending", wr_ready_out, 0);
    check_eq("no_ack_same_nf", swap_ack_out, 0);
    wr_valid_in = 0;
    tick(); tick();
    nf_in = 1;
    tick();
    nf_in = 0; front_exp = 1; exp_page = 0; clr_exp = '0; clr_cnt = 0; clr_mon = 1;
    #1 check_eq("swap_ack_1", swap_ack_out, 1);

    // Reset in the middle of the clear
    for (int i = 0; i < 2000 && clr_exp != 16'd1000; i++) tick();
    check_eq("clr_reach_1000", clr_exp, 1000);
    clr_mon = 0;
    #1 rst_n_in = 1'b0;
    #1;
    check_eq("mid_rst_we", mem_we_out, 0);
    check_eq("mid_rst_addr", mem_addr_out, 0);
    check_eq("mid_rst_busy", busy_out, 0);
    check_eq("mid_rst_ready", wr_ready_out, 0);
    check_eq("mid_rst_hout", hcount_out, 0);
    check_eq("mid_rst_vout", vcount_out, 0);
    tick();
    rst_n_in = 1'b1; front_exp = 0;
    wr_valid_in = 1; wr_x_in = 9'd1; wr_y_in = 8'd0; wr_data_in = 8'h05;
    #1;
    check_eq("post_rst_busy", busy_out, 0);
    check_eq("post_rst_draw", wr_ready_out, 1);
    tick();
    wr_valid_in = 0;
    #1 check_eq("post_rst_back_pg", mem_addr_out, {1'b1, 16'd1});
    vcount_in = 10'd0; hcount_in = 11'd8; ad_in = 1;
    tick();
    ad_in = 0;
    #1 check_eq("post_rst_front_pg", mem_addr_out, {1'b0, 16'd2});
    tick();

    // Full swap followed by a complete clear of page 0 with live scan-out
    vcount_in = 10'd100; swap_req_in = 1;
    tick();
    swap_req_in = 0;
    repeat (3) tick();
    nf_in = 1;
    tick();
    nf_in = 0; front_exp = 1; exp_page = 0; clr_exp = '0; clr_cnt = 0;
    clr_bad = 0; scan_lost = 0; clr_mon = 1;
    #1 check_eq("swap_ack_2", swap_ack_out, 1);
    vcount_in = 10'd0; hcount_in = 11'd0; ad_in = 1;
    tick();
    ad_in = 0;
    #1;
    check_eq("ack_one_cycle", swap_ack_out, 0);
    check_eq("rd_page1", mem_addr_out, {1'b1, 16'd0});
    for (int i = 0; i < 70000; i++) begin
      if (!busy_out) begin
        fall_cnt = clr_cnt;
        break;
      end
      hcount_in = 11'(i % 20);
      ad_in = (i < 1000) && ((i % 20) < 16);
      tick();
    end
    ad_in = 0;
    tick(); tick();
    clr_mon = 0;
    check_eq("clr_busy_fell", busy_out, 0);
    check_eq("clr_fall_point", fall_cnt, 57599);
    check_eq("clr_writes", clr_cnt, 57600);
    check_eq("clr_bad_writes", clr_bad, 0);
    check_eq("clr_scan_lost", scan_lost, 0);
    check_eq("clr_then_draw", wr_ready_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
